closest_hit: RTL and testbench

Per-ray nearest-intersection reducer that sits directly upstream of the hit-point/normal stage. It accepts one ray, then a burst of per-object intersection candidates (t value, hit flag, object record), and keeps the smallest valid positive t. It then emits the winning t, object and ray on three independent AXI-stream outputs that feed the hit-point stage's t, obj and ray inputs. Rays that hit nothing go out on a separate miss stream for background shading.

---
 rtl/closest_hit.sv | 181 ++++++++++++++++++
 tb/tb_closest_hit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/closest_hit.sv
// Per-ray nearest-intersection reducer: keeps the smallest valid positive t of a
// candidate burst and emits it on t/obj/ray streams, or the ray direction on a miss stream.
module closest_hit #(
  parameter int              SIZE  = 32,
  parameter logic [SIZE-1:0] T_EPS = 32'h3A83126F,
  parameter logic [SIZE-1:0] T_MAX = 32'h7F800000
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic [6*SIZE-1:0] ray_in_axis_tdata,
  input  logic              ray_in_axis_tvalid,
  output logic              ray_in_axis_tready,

  input  logic [SIZE-1:0]   cand_axis_t,
  input  logic              cand_axis_thit,
  input  logic [6*SIZE-1:0] cand_axis_obj,
  input  logic              cand_axis_is_cylinder,
  input  logic              cand_axis_tlast,
  input  logic              cand_axis_tvalid,
  output logic              cand_axis_tready,

  output logic [SIZE-1:0]   t_axis_tdata,
  output logic              t_axis_tvalid,
  input  logic              t_axis_tready,

  output logic [6*SIZE-1:0] obj_axis_tdata,
  output logic              obj_axis_is_cylinder,
  output logic              obj_axis_tvalid,
  input  logic              obj_axis_tready,

  output logic [6*SIZE-1:0] ray_axis_tdata,
  output logic              ray_axis_tvalid,
  input  logic              ray_axis_tready,

  output logic [3*SIZE-1:0] miss_axis_tdata,
  output logic              miss_axis_tvalid,
  input  logic              miss_axis_tready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT_HIT,
    EMIT_MISS
  } state_t;

  state_t state;
  state_t state_next;

  logic [6*SIZE-1:0] ray_q;
  logic [SIZE-1:0]   best_t;
  logic [6*SIZE-1:0] best_obj;
  logic              best_cyl;
  logic              best_valid;
  logic              t_done;
  logic              obj_done;
  logic              ray_done;

  logic              ray_fire;
  logic              cand_fire;
  logic              t_fire;
  logic              obj_fire;
  logic              ray_out_fire;
  logic              miss_fire;
  logic [SIZE-2:0]   cand_mag;
  logic              cand_qualifies;
  logic              cand_better;
  logic              all_done;

  assign ray_fire     = ray_in_axis_tvalid & ray_in_axis_tready;
  assign cand_fire    = cand_axis_tvalid & cand_axis_tready;
  assign t_fire       = t_axis_tvalid & t_axis_tready;
  assign obj_fire     = obj_axis_tvalid & obj_axis_tready;
  assign ray_out_fire = ray_axis_tvalid & ray_axis_tready;
  assign miss_fire    = miss_axis_tvalid & miss_axis_tready;

  // Magnitude bits order non-negative IEEE floats like unsigned integers.
  assign cand_mag       = cand_axis_t[SIZE-2:0];
  assign cand_qualifies = cand_axis_thit & ~cand_axis_t[SIZE-1] &
                          (cand_mag > T_EPS[SIZE-2:0]) &
                          (cand_mag < T_MAX[SIZE-2:0]);
  assign cand_better    = cand_qualifies &
                          (~best_valid | (cand_mag < best_t[SIZE-2:0]));

  assign all_done = (t_done | t_fire) & (obj_done | obj_fire) & (ray_done | ray_out_fire);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ray_fire) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (cand_fire && cand_axis_tlast) begin
          state_next = (best_valid || cand_qualifies) ? EMIT_HIT : EMIT_MISS;
        end
      end
      EMIT_HIT: begin
        if (all_done) begin
          state_next = IDLE;
        end
      end
      EMIT_MISS: begin
        if (miss_fire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ray_q <= '0;
    end else if (ray_fire) begin
      ray_q <= ray_in_axis_tdata;
    end
  end

  // Strict less-than keeps the earliest object on equal t.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      best_valid <= 1'b0;
      best_t     <= '0;
      best_obj   <= '0;
      best_cyl   <= 1'b0;
    end else if (ray_fire) begin
      best_valid <= 1'b0;
    end else if (cand_fire && cand_better) begin
      best_valid <= 1'b1;
      best_t     <= cand_axis_t;
      best_obj   <= cand_axis_obj;
      best_cyl   <= cand_axis_is_cylinder;
    end
  end

  // Done flags keep each output stream from re-asserting for the same ray.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      t_done   <= 1'b0;
      obj_done <= 1'b0;
      ray_done <= 1'b0;
    end else if (state != EMIT_HIT) begin
      t_done   <= 1'b0;
      obj_done <= 1'b0;
      ray_done <= 1'b0;
    end else begin
      t_done   <= t_done | t_fire;
      obj_done <= obj_done | obj_fire;
      ray_done <= ray_done | ray_out_fire;
    end
  end

  assign ray_in_axis_tready   = (state == IDLE);
  assign cand_axis_tready     = (state == ACCUM);

  assign t_axis_tvalid        = (state == EMIT_HIT) & ~t_done;
  assign obj_axis_tvalid      = (state == EMIT_HIT) & ~obj_done;
  assign ray_axis_tvalid      = (state == EMIT_HIT) & ~ray_done;
  assign miss_axis_tvalid     = (state == EMIT_MISS);

  assign t_axis_tdata         = best_t;
  assign obj_axis_tdata       = best_obj;
  assign obj_axis_is_cylinder = best_cyl;
  assign ray_axis_tdata       = ray_q;
  assign miss_axis_tdata      = ray_q[6*SIZE-1:3*SIZE];

endmodule

// File: tb/tb_closest_hit.sv
// Self-checking bench for closest_hit: directed and randomized ray bursts checked
// against an argmin-over-list reference model with staggered downstream readiness.
module tb_closest_hit;

  localparam int SIZE = 32;
  localparam int OW   = 6 * SIZE;
  localparam logic [31:0] EPS_BITS = 32'h3A83126F;
  localparam logic [31:0] MAX_BITS = 32'h7F800000;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [OW-1:0]   ray_in_axis_tdata;
  logic            ray_in_axis_tvalid;
  logic            ray_in_axis_tready;
  logic [SIZE-1:0] cand_axis_t;
  logic            cand_axis_thit;
  logic [OW-1:0]   cand_axis_obj;
  logic            cand_axis_is_cylinder;
  logic            cand_axis_tlast;
  logic            cand_axis_tvalid;
  logic            cand_axis_tready;
  logic [SIZE-1:0] t_axis_tdata;
  logic            t_axis_tvalid;
  logic            t_axis_tready;
  logic [OW-1:0]   obj_axis_tdata;
  logic            obj_axis_is_cylinder;
  logic            obj_axis_tvalid;
  logic            obj_axis_tready;
  logic [OW-1:0]   ray_axis_tdata;
  logic            ray_axis_tvalid;
  logic            ray_axis_tready;
  logic [3*SIZE-1:0] miss_axis_tdata;
  logic            miss_axis_tvalid;
  logic            miss_axis_tready;

  int tests = 0;
  int fails = 0;

  logic [OW-1:0] cur_ray;
  logic [31:0]   q_t[$];
  logic          q_hit[$];
  logic [OW-1:0] q_obj[$];
  logic          q_cyl[$];

  always #5 aclk = ~aclk;

  closest_hit dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .ray_in_axis_tdata     (ray_in_axis_tdata),
    .ray_in_axis_tvalid    (ray_in_axis_tvalid),
    .ray_in_axis_tready    (ray_in_axis_tready),
    .cand_axis_t           (cand_axis_t),
    .cand_axis_thit        (cand_axis_thit),
    .cand_axis_obj         (cand_axis_obj),
    .cand_axis_is_cylinder (cand_axis_is_cylinder),
    .cand_axis_tlast       (cand_axis_tlast),
    .cand_axis_tvalid      (cand_axis_tvalid),
    .cand_axis_tready      (cand_axis_tready),
    .t_axis_tdata          (t_axis_tdata),
    .t_axis_tvalid         (t_axis_tvalid),
    .t_axis_tready         (t_axis_tready),
    .obj_axis_tdata        (obj_axis_tdata),
    .obj_axis_is_cylinder  (obj_axis_is_cylinder),
    .obj_axis_tvalid       (obj_axis_tvalid),
    .obj_axis_tready       (obj_axis_tready),
    .ray_axis_tdata        (ray_axis_tdata),
    .ray_axis_tvalid       (ray_axis_tvalid),
    .ray_axis_tready       (ray_axis_tready),
    .miss_axis_tdata       (miss_axis_tdata),
    .miss_axis_tvalid      (miss_axis_tvalid),
    .miss_axis_tready      (miss_axis_tready)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] rand_record();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic add_cand(input logic [31:0] t, input logic hit);
    q_t.push_back(t);
    q_hit.push_back(hit);
    q_obj.push_back(rand_record());
    q_cyl.push_back($urandom_range(0, 1) == 1);
  endtask

  task automatic add_random_cand();
    int kind;
    kind = $urandom_range(0, 9);
    case (kind)
      0: add_cand({1'b1, 31'($urandom())}, 1'b1);
      1: add_cand($urandom_range(0, 32'h3A83126F), 1'b1);
      2: add_cand(EPS_BITS, 1'b1);
      3: add_cand(($urandom_range(0, 1) == 1) ? MAX_BITS : (32'h7FC00000 | $urandom_range(0, 255)), 1'b1);
      4: add_cand(32'h3F800000 + ($urandom_range(0, 7) << 20), 1'b0);
      default: add_cand(32'h3F800000 + ($urandom_range(0, 7) << 20), 1'b1);
    endcase
  endtask

  // A hit counts when it is a positive value strictly between epsilon and the cap.
  function automatic bit qualifies(input logic [31:0] t, input logic hit);
    int unsigned mag;
    mag = {1'b0, t[30:0]};
    return hit && (t[31] == 1'b0) && (mag > {1'b0, EPS_BITS[30:0]}) && (mag < {1'b0, MAX_BITS[30:0]});
  endfunction

  // Index of the first occurrence of the smallest qualifying t, or -1 when none qualify.
  function automatic int nearest_index();
    int best;
    best = -1;
    for (int i = 0; i < q_t.size(); i++) begin
      if (qualifies(q_t[i], q_hit[i])) begin
        if (best < 0 || q_t[i][30:0] < q_t[best][30:0]) best = i;
      end
    end
    return best;
  endfunction

  task automatic send_ray(input logic [OW-1:0] r);
    int cnt;
    cur_ray = r;
    ray_in_axis_tdata  = r;
    ray_in_axis_tvalid = 1'b1;
    cnt = 0;
    while (!ray_in_axis_tready && cnt < 50) begin
      @(negedge aclk);
      cnt++;
    end
    check_bit("ray_in_ready", ray_in_axis_tready, 1'b1);
    @(negedge aclk);
    ray_in_axis_tvalid = 1'b0;
  endtask

  task automatic apply_stimulus(input int max_gap, input bit stop_before_last);
    int cnt;
    int last;
    last = stop_before_last ? q_t.size() - 1 : q_t.size();
    for (int i = 0; i < last; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge aclk);
      cand_axis_t           = q_t[i];
      cand_axis_thit        = q_hit[i];
      cand_axis_obj         = q_obj[i];
      cand_axis_is_cylinder = q_cyl[i];
      cand_axis_tlast       = (i == q_t.size() - 1);
      cand_axis_tvalid      = 1'b1;
      cnt = 0;
      while (!cand_axis_tready && cnt < 50) begin
        @(negedge aclk);
        cnt++;
      end
      check_bit("cand_ready", cand_axis_tready, 1'b1);
      @(negedge aclk);
      cand_axis_tvalid = 1'b0;
      cand_axis_tlast  = 1'b0;
    end
  endtask

  task automatic check_output(input int dt, input int dobj, input int dr, input int dm);
    int idx;
    int c;
    bit tacc, oacc, racc, macc;
    idx = nearest_index();
    c = 0;
    if (idx >= 0) begin
      tacc = 0; oacc = 0; racc = 0;
      while (!(tacc && oacc && racc) && c < 64) begin
        check_bit("t_valid", t_axis_tvalid, !tacc);
        check_bit("obj_valid", obj_axis_tvalid, !oacc);
        check_bit("ray_valid", ray_axis_tvalid, !racc);
        check_bit("miss_valid_on_hit", miss_axis_tvalid, 1'b0);
        check_bit("inputs_blocked", ray_in_axis_tready | cand_axis_tready, 1'b0);
        if (!tacc) check_word("t_data", {160'b0, t_axis_tdata}, {160'b0, q_t[idx]});
        if (!oacc) check_word("obj_data", obj_axis_tdata, q_obj[idx]);
        if (!oacc) check_bit("obj_cyl", obj_axis_is_cylinder, q_cyl[idx]);
        if (!racc) check_word("ray_data", ray_axis_tdata, cur_ray);
        t_axis_tready   = (c >= dt);
        obj_axis_tready = (c >= dobj);
        ray_axis_tready = (c >= dr);
        tacc |= t_axis_tready;
        oacc |= obj_axis_tready;
        racc |= ray_axis_tready;
        @(negedge aclk);
        c++;
      end
      check_bit("hit_emit_bound", tacc && oacc && racc, 1'b1);
    end else begin
      macc = 0;
      while (!macc && c < 64) begin
        check_bit("miss_valid", miss_axis_tvalid, 1'b1);
        check_word("miss_data", {96'b0, miss_axis_tdata}, {96'b0, cur_ray[OW-1:3*SIZE]});
        check_bit("hit_valids_on_miss", t_axis_tvalid | obj_axis_tvalid | ray_axis_tvalid, 1'b0);
        check_bit("inputs_blocked_miss", ray_in_axis_tready | cand_axis_tready, 1'b0);
        miss_axis_tready = (c >= dm);
        macc |= miss_axis_tready;
        @(negedge aclk);
        c++;
      end
      check_bit("miss_emit_bound", macc, 1'b1);
    end
    t_axis_tready = 1'b0; obj_axis_tready = 1'b0; ray_axis_tready = 1'b0; miss_axis_tready = 1'b0;
    check_bit("valids_low_after", t_axis_tvalid | obj_axis_tvalid | ray_axis_tvalid | miss_axis_tvalid, 1'b0);
    check_bit("back_to_idle", ray_in_axis_tready, 1'b1);
    q_t.delete(); q_hit.delete(); q_obj.delete(); q_cyl.delete();
  endtask

  task automatic run_ray(input int max_gap, input int dt, input int dobj, input int dr, input int dm);
    send_ray(rand_record());
    apply_stimulus(max_gap, 1'b0);
    check_output(dt, dobj, dr, dm);
  endtask

  task automatic check_all_quiet(input string tag);
    check_bit(tag, t_axis_tvalid | obj_axis_tvalid | ray_axis_tvalid | miss_axis_tvalid | cand_axis_tready, 1'b0);
    check_bit("reset_ray_ready", ray_in_axis_tready, 1'b1);
  endtask

  initial begin
    aresetn = 1'b0;
    ray_in_axis_tdata = '0; ray_in_axis_tvalid = 1'b0;
    cand_axis_t = '0; cand_axis_thit = 1'b0; cand_axis_obj = '0;
    cand_axis_is_cylinder = 1'b0; cand_axis_tlast = 1'b0; cand_axis_tvalid = 1'b0;
    t_axis_tready = 1'b0; obj_axis_tready = 1'b0; ray_axis_tready = 1'b0; miss_axis_tready = 1'b0;
    #12;
    check_all_quiet("reset_quiet");
    check_word("reset_t_data", {160'b0, t_axis_tdata}, '0);
    check_word("reset_obj_data", obj_axis_tdata, '0);
    check_word("reset_ray_data", ray_axis_tdata, '0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Nearest wins.
    add_cand(32'h40000000, 1'b1); add_cand(32'h3F000000, 1'b1); add_cand(32'h3F800000, 1'b1);
    run_ray(0, 0, 0, 0, 0);

    // Rejection of negative, sub-epsilon, infinite and non-hit candidates.
    add_cand(32'hBF800000, 1'b1); add_cand(32'h3A000000, 1'b1); add_cand(32'h7F800000, 1'b1);
    add_cand(32'h3F800000, 1'b0); add_cand(32'h40400000, 1'b1);
    run_ray(1, 1, 0, 2, 0);

    // All miss.
    add_cand(32'h3F800000, 1'b0); add_cand(32'h40000000, 1'b0); add_cand(32'h3F000000, 1'b0);
    run_ray(0, 0, 0, 0, 3);

    // Tie keeps the first object; single-beat burst.
    add_cand(32'h3F800000, 1'b1); add_cand(32'h3F800000, 1'b1);
    run_ray(0, 0, 0, 0, 0);
    add_cand(32'h3FC00000, 1'b1);
    run_ray(0, 0, 0, 0, 0);

    // Staggered backpressure: ray stream held off five cycles.
    add_cand(32'h40800000, 1'b1); add_cand(32'h40200000, 1'b1);
    run_ray(0, 0, 0, 5, 0);

    // Reset mid-ACCUM.
    add_cand(32'h3F800000, 1'b1); add_cand(32'h3F000000, 1'b1); add_cand(32'h40000000, 1'b1);
    send_ray(rand_record());
    apply_stimulus(0, 1'b1);
    #2 aresetn = 1'b0;
    #1 check_all_quiet("reset_mid_accum");
    @(negedge aclk);
    aresetn = 1'b1;
    q_t.delete(); q_hit.delete(); q_obj.delete(); q_cyl.delete();
    add_cand(32'h40400000, 1'b1); add_cand(32'h3F400000, 1'b1);
    run_ray(1, 0, 1, 2, 0);

    // Reset mid-EMIT_HIT.
    add_cand(32'h3F800000, 1'b1);
    send_ray(rand_record());
    apply_stimulus(0, 1'b0);
    check_bit("emit_before_reset", t_axis_tvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1 check_all_quiet("reset_mid_emit");
    check_word("reset_emit_t_cleared", {160'b0, t_axis_tdata}, '0);
    @(negedge aclk);
    aresetn = 1'b1;
    q_t.delete(); q_hit.delete(); q_obj.delete(); q_cyl.delete();
    add_cand(32'h40000000, 1'b1); add_cand(32'h3E800000, 1'b1); add_cand(32'h3F000000, 1'b1);
    run_ray(0, 2, 1, 0, 0);

    // Randomized bursts.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(1, 6)) add_random_cand();
      run_ray(2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
